mem_responder: RTL and testbench
================================

# mem_responder

Single-clock memory responder that serves the request/strobe memory interface driven by compute masters such as the matrix-multiply engine. It owns a word-addressed storage array, performs writes in the request cycle, and returns read data after a fixed, parameterised latency with a valid strobe. A second, lower-priority host port preloads operands and dumps results. It sits between one master and the test/host harness.

## Interface
- MEM_AW, 16: address width of both ports.
- MEM_DW, 32: data word width.
- DEPTH_AW, 10: storage is 2**DEPTH_AW words; addresses at or above 2**DEPTH_AW are out of range.
- RD_LAT, 1: read latency in cycles, legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- mem_req  in  1  master access strobe; one access per cycle while high.
- mem_write  in  1  1 = write, 0 = read; qualified by mem_req.
- mem_addr  in  MEM_AW  master word address.
- mem_wdata  in  MEM_DW  master write data.
- mem_rdata_vld  out  1  read data valid, one-cycle pulse per read.
- mem_rdata  out  MEM_DW  read data; holds its last value when not valid.
- hst_req  in  1  host access request.
- hst_write  in  1  host write/read select.
- hst_addr  in  MEM_AW  host word address.
- hst_wdata  in  MEM_DW  host write data.
- hst_gnt  out  1  combinational; high when the host request is accepted this cycle.
- hst_rdata_vld  out  1  host read data valid.
- hst_rdata  out  MEM_DW  host read data.
- oor_err  out  1  sticky flag; set by any accepted out-of-range access.

## Operation
- Each cycle at most one access is accepted. The master port has absolute priority. hst_gnt = hst_req & ~mem_req.
- There is no master backpressure: every cycle with mem_req=1 is an access. Masters may hold mem_req high across consecutive cycles with changing addresses.
- Write: the array is updated at the accepting edge. A read of the same address in the next cycle returns the new data.
- Read: the array is read at the accepting edge. The result enters a delay line tagged with the port (M/H). It emerges as the matching *_rdata_vld pulse exactly RD_LAT cycles after acceptance.
- Read results never collide: one access is accepted per cycle and the latency is fixed, so back-to-back reads produce back-to-back vld pulses. Mixed-port reads come out in issue order.
- Out-of-range access: a write is dropped; a read returns 0 with vld asserted as normal. In both cases oor_err is set and stays set until rst.
- Address arithmetic: only the low DEPTH_AW bits index the array, with no wrap-around aliasing because out-of-range accesses are rejected.
- State: the delay line (vld, port tag, data per stage) plus oor_err. No other FSM is needed.

## Timing
- Reset values: mem_rdata_vld=0, hst_rdata_vld=0, mem_rdata=0, hst_rdata=0, oor_err=0, all delay-line valids=0. Array contents are not reset.
- Reset mid-operation: all in-flight reads are discarded and no vld pulse follows. A write on the reset edge is not performed.
- Latency: a read accepted at edge E drives *_rdata_vld high during the cycle following edge E+RD_LAT-1, i.e. RD_LAT=1 means the data is valid the cycle after the request.
- Simultaneous mem_req and hst_req: the master is served, hst_gnt=0, and the host must hold its request.
- Throughput: 1 access/cycle aggregate, sustained indefinitely.

## Structure
- Package mem_responder_pkg holds the port-tag encoding (TAG_MEM, TAG_HST), the RD_LAT legality bounds, and the delay-line stage struct {vld, tag, data}.
- Sub-module mem_rd_pipe: a parameterised RD_LAT-stage delay line with synchronous clear, instantiated once. The top level holds the arbiter, array, range check and oor_err.

## Test plan
- Host writes 0x11,0x22,0x33 to addresses 0..2. The master then reads 0,1,2 on consecutive cycles with RD_LAT=2 -> mem_rdata_vld high for 3 consecutive cycles starting 2 cycles after the first request, data 0x11,0x22,0x33.
- Master writes 0xDEAD to address 5, then reads address 5 on the next cycle -> returns 0xDEAD after RD_LAT.
- mem_req and hst_req both high for 4 cycles -> hst_gnt=0 throughout. The host read is granted the cycle mem_req drops, and hst_rdata_vld follows RD_LAT later.
- Master reads address 2**DEPTH_AW -> rdata=0, vld pulses, oor_err=1 and stays high. A master write to that address leaves address 0 unchanged.
- Issue 3 reads with RD_LAT=4 and assert rst one cycle after the last read -> no vld pulses after reset, and all outputs are 0.
- Interleaved master/host reads with RD_LAT=1..4 against a scoreboard model -> every result appears on the correct port, in order, at the exact cycle.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared types and constants for the memory responder.
//   port_tag_e  - identifies which port issued a read (master or host)
//   RD_LAT_*    - legal bounds for the read latency parameter
//   rd_stage_t  - one entry of the read-return delay line {vld, tag, data}
package mem_responder_pkg;

  typedef enum logic {
    TAG_MEM = 1'b0,
    TAG_HST = 1'b1
  } port_tag_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;

  // Data width carried by the delay-line stage; the top checks it matches MEM_DW.
  localparam int unsigned STG_DW = 32;

  typedef struct packed {
    logic              vld;
    port_tag_e         tag;
    logic [STG_DW-1:0] data;
  } rd_stage_t;

  function automatic logic rd_lat_ok(input int unsigned lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: bundles the master request/strobe port, the host port and
// the sticky error flag of the memory responder.
//   master modport - the requesting side (compute master + host harness)
//   slave modport  - the responder side (mem_responder)
//   mem_*  : master access strobe, write select, address, write data, read return
//   hst_*  : host request, write select, address, write data, grant, read return
//   oor_err: sticky out-of-range access flag
interface mem_responder_if #(
  parameter int unsigned MEM_AW = 16,
  parameter int unsigned MEM_DW = 32
);
  logic              mem_req;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_addr;
  logic [MEM_DW-1:0] mem_wdata;
  logic              mem_rdata_vld;
  logic [MEM_DW-1:0] mem_rdata;

  logic              hst_req;
  logic              hst_write;
  logic [MEM_AW-1:0] hst_addr;
  logic [MEM_DW-1:0] hst_wdata;
  logic              hst_gnt;
  logic              hst_rdata_vld;
  logic [MEM_DW-1:0] hst_rdata;

  logic              oor_err;

  modport master (
    output mem_req, mem_write, mem_addr, mem_wdata,
    input  mem_rdata_vld, mem_rdata,
    output hst_req, hst_write, hst_addr, hst_wdata,
    input  hst_gnt, hst_rdata_vld, hst_rdata,
    input  oor_err
  );

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_wdata,
    output mem_rdata_vld, mem_rdata,
    input  hst_req, hst_write, hst_addr, hst_wdata,
    output hst_gnt, hst_rdata_vld, hst_rdata,
    output oor_err
  );
endinterface

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: RD_LAT-stage delay line for read returns with synchronous clear.
//   clk     - clock, rising edge
//   rst     - synchronous active-high clear of every stage
//   stage_i - entry captured at the accepting edge
//   stage_o - entry emerging RD_LAT-1 edges after capture
module mem_rd_pipe
  import mem_responder_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  rd_stage_t stage_i,
  output rd_stage_t stage_o
);

  rd_stage_t stage_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= stage_i;
      for (int unsigned i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign stage_o = stage_q[RD_LAT-1];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-clock word-addressed memory serving a master port
// (absolute priority) and a lower-priority host port, one access per cycle.
// Writes land at the accepting edge; reads return RD_LAT cycles later with a
// one-cycle valid pulse on the issuing port. Out-of-range accesses drop writes,
// return zero for reads and set the sticky oor_err flag.
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - mem_responder_if.slave (master port, host port, oor_err)
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned MEM_AW   = 16,
  parameter int unsigned MEM_DW   = 32,
  parameter int unsigned DEPTH_AW = 10,
  parameter int unsigned RD_LAT   = 1
) (
  input logic           clk,
  input logic           rst,
  mem_responder_if.slave bus
);

  if (!rd_lat_ok(RD_LAT)) begin : g_lat_chk
    $error("mem_responder: RD_LAT must be within 1..4");
  end
  if (MEM_DW != STG_DW) begin : g_dw_chk
    $error("mem_responder: MEM_DW must equal the delay-line stage width");
  end

  // Arbitration and access decode
  logic                acc_vld;
  logic                acc_host;
  logic                acc_wr;
  logic [MEM_AW-1:0]   acc_addr;
  logic [MEM_DW-1:0]   acc_wdata;
  logic [DEPTH_AW-1:0] acc_idx;
  logic                in_range;

  always_comb begin
    acc_vld   = bus.mem_req | bus.hst_req;
    acc_host  = bus.hst_req & ~bus.mem_req;
    acc_wr    = bus.mem_req ? bus.mem_write : bus.hst_write;
    acc_addr  = bus.mem_req ? bus.mem_addr  : bus.hst_addr;
    acc_wdata = bus.mem_req ? bus.mem_wdata : bus.hst_wdata;
    acc_idx   = acc_addr[DEPTH_AW-1:0];
    // Any set bit above the index field is out of range, so no aliasing.
    in_range  = (acc_addr >> DEPTH_AW) == '0;
  end

  assign bus.hst_gnt = acc_host;

  // Storage array (not reset); a write on the reset edge is suppressed.
  logic [MEM_DW-1:0] mem_q [2**DEPTH_AW];

  always_ff @(posedge clk) begin
    if (!rst && acc_vld && acc_wr && in_range) mem_q[acc_idx] <= acc_wdata;
  end

  // Read return path
  rd_stage_t pipe_in;
  rd_stage_t pipe_out;

  always_comb begin
    pipe_in      = '0;
    pipe_in.vld  = acc_vld & ~acc_wr;
    pipe_in.tag  = acc_host ? TAG_HST : TAG_MEM;
    pipe_in.data = in_range ? mem_q[acc_idx] : '0;
  end

  mem_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .stage_i (pipe_in),
    .stage_o (pipe_out)
  );

  logic mem_vld;
  logic hst_vld;
  assign mem_vld = pipe_out.vld && (pipe_out.tag == TAG_MEM);
  assign hst_vld = pipe_out.vld && (pipe_out.tag == TAG_HST);

  // The delay line's last stage is presented directly while valid; these
  // registers only remember it so rdata holds between pulses.
  logic [MEM_DW-1:0] mem_hold_q, mem_hold_d;
  logic [MEM_DW-1:0] hst_hold_q, hst_hold_d;

  always_comb begin
    mem_hold_d = mem_vld ? pipe_out.data : mem_hold_q;
    hst_hold_d = hst_vld ? pipe_out.data : hst_hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_hold_q <= '0;
      hst_hold_q <= '0;
    end else begin
      mem_hold_q <= mem_hold_d;
      hst_hold_q <= hst_hold_d;
    end
  end

  assign bus.mem_rdata_vld = mem_vld;
  assign bus.hst_rdata_vld = hst_vld;
  assign bus.mem_rdata     = mem_hold_d;
  assign bus.hst_rdata     = hst_hold_d;

  // Sticky out-of-range flag
  logic oor_err_q, oor_err_d;

  assign oor_err_d = oor_err_q | (acc_vld & ~in_range);

  always_ff @(posedge clk) begin
    if (rst) oor_err_q <= 1'b0;
    else     oor_err_q <= oor_err_d;
  end

  assign bus.oor_err = oor_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: drives identical stimulus into four responders with
// RD_LAT = 1..4 and checks every output each cycle against a reference model
// built from an access log (which edge accepted which read, and when resets hit).
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        d_mr, d_mw, d_hr, d_hw;
  logic [15:0] d_ma, d_ha;
  logic [31:0] d_mwd, d_hwd;

  logic        o_mv [4];
  logic        o_hv [4];
  logic        o_gnt[4];
  logic        o_oor[4];
  logic [31:0] o_md [4];
  logic [31:0] o_hd [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_responder_if #(.MEM_AW(16), .MEM_DW(32)) bus ();
    assign bus.mem_req   = d_mr;
    assign bus.mem_write = d_mw;
    assign bus.mem_addr  = d_ma;
    assign bus.mem_wdata = d_mwd;
    assign bus.hst_req   = d_hr;
    assign bus.hst_write = d_hw;
    assign bus.hst_addr  = d_ha;
    assign bus.hst_wdata = d_hwd;
    mem_responder #(
      .MEM_AW   (16),
      .MEM_DW   (32),
      .DEPTH_AW (10),
      .RD_LAT   (g + 1)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign o_mv[g]  = bus.mem_rdata_vld;
    assign o_hv[g]  = bus.hst_rdata_vld;
    assign o_gnt[g] = bus.hst_gnt;
    assign o_oor[g] = bus.oor_err;
    assign o_md[g]  = bus.mem_rdata;
    assign o_hd[g]  = bus.hst_rdata;
  end

  int nchk = 0;
  int nerr = 0;

  // Reference model state
  localparam int NE = 4096;
  int          n = 0;               // number of edges seen
  bit          rec_v [NE];          // a read was accepted at this edge
  bit          rec_t [NE];          // 0 = master, 1 = host
  logic [31:0] rec_d [NE];          // data that read returns
  bit          rst_e [NE];          // reset was sampled at this edge
  logic [31:0] ref_mem [1024];
  bit          oor_m;
  logic [31:0] hold_m [4];
  logic [31:0] hold_h [4];

  task automatic chk1(input string tag, input int g, input logic obs, input logic exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s lat%0d observed=%b expected=%b", tag, g + 1, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s lat%0d observed=%h expected=%h", tag, g + 1, obs, exp);
    end
  endtask

  task automatic model_acc(input bit t, input logic w, input logic [15:0] a, input logic [31:0] d);
    bit inr;
    inr = (a < 16'd1024);
    if (!inr) oor_m = 1'b1;
    if (w) begin
      if (inr) ref_mem[a[9:0]] = d;
      rec_v[n] = 1'b0;
    end else begin
      rec_v[n] = 1'b1;
      rec_t[n] = t;
      rec_d[n] = inr ? ref_mem[a[9:0]] : 32'h0;
    end
  endtask

  // One clock cycle: apply inputs, check grant, take the edge, update the model,
  // then check every instance's outputs for the cycle that follows the edge.
  task automatic step(input logic r, input logic mr, input logic mw, input logic [15:0] ma,
                      input logic [31:0] mwd, input logic hr, input logic hw,
                      input logic [15:0] ha, input logic [31:0] hwd);
    rst = r; d_mr = mr; d_mw = mw; d_ma = ma; d_mwd = mwd;
    d_hr = hr; d_hw = hw; d_ha = ha; d_hwd = hwd;
    #1;
    for (int g = 0; g < 4; g++) chk1("hst_gnt", g, o_gnt[g], hr & ~mr);
    @(posedge clk);
    #1;
    n++;
    if (r) begin
      rst_e[n] = 1'b1;
      rec_v[n] = 1'b0;
      oor_m    = 1'b0;
    end else if (mr) model_acc(1'b0, mw, ma, mwd);
    else if (hr)     model_acc(1'b1, hw, ha, hwd);
    else             rec_v[n] = 1'b0;
    for (int g = 0; g < 4; g++) begin
      int e;
      bit ev, em, eh;
      e  = n - g;                   // edge whose read emerges now for RD_LAT = g+1
      ev = 1'b0;
      if (r) begin
        hold_m[g] = 32'h0;
        hold_h[g] = 32'h0;
      end
      if (e >= 1 && rec_v[e]) begin
        ev = 1'b1;
        for (int k = e + 1; k <= n; k++) if (rst_e[k]) ev = 1'b0;
      end
      em = ev && (rec_t[e] == 1'b0);
      eh = ev && (rec_t[e] == 1'b1);
      if (em) hold_m[g] = rec_d[e];
      if (eh) hold_h[g] = rec_d[e];
      chk1 ("mem_rdata_vld", g, o_mv[g], em);
      chk1 ("hst_rdata_vld", g, o_hv[g], eh);
      chk32("mem_rdata",     g, o_md[g], hold_m[g]);
      chk32("hst_rdata",     g, o_hd[g], hold_h[g]);
      chk1 ("oor_err",       g, o_oor[g], oor_m);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask
  task automatic mrd(input logic [15:0] a);
    step(1'b0, 1'b1, 1'b0, a, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask
  task automatic mwr(input logic [15:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, 1'b1, a, d, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  function automatic logic [15:0] pick_addr();
    if ($urandom_range(0, 15) == 0) return 16'(1024 + $urandom_range(0, 64511));
    return 16'($urandom_range(0, 31));
  endfunction

  initial begin
    logic [31:0] pd;
    // Reset
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    for (int g = 0; g < 4; g++) begin
      chk1 ("rst_mem_vld", g, o_mv[g], 1'b0);
      chk32("rst_mem_rdata", g, o_md[g], 32'h0);
      chk1 ("rst_oor", g, o_oor[g], 1'b0);
    end

    // Host preload of addresses 0..31
    for (int i = 0; i < 32; i++) begin
      pd = (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : (i == 2) ? 32'h33 : $urandom;
      step(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 16'(i), pd);
    end

    // Back-to-back master reads, RD_LAT=2 instance (index 1)
    mrd(16'd0);  chk1("tp1_vld0", 1, o_mv[1], 1'b0);
    mrd(16'd1);  chk1("tp1_vld1", 1, o_mv[1], 1'b1); chk32("tp1_d1", 1, o_md[1], 32'h11);
    mrd(16'd2);  chk1("tp1_vld2", 1, o_mv[1], 1'b1); chk32("tp1_d2", 1, o_md[1], 32'h22);
    idle();      chk1("tp1_vld3", 1, o_mv[1], 1'b1); chk32("tp1_d3", 1, o_md[1], 32'h33);
    idle();      chk1("tp1_vld4", 1, o_mv[1], 1'b0); chk32("tp1_hold", 1, o_md[1], 32'h33);

    // Write then read-after-write
    mwr(16'd5, 32'hDEAD);
    mrd(16'd5);  chk32("raw_l1", 0, o_md[0], 32'hDEAD);
    idle();      chk32("raw_l2", 1, o_md[1], 32'hDEAD);
    idle(); idle(); idle();

    // Master and host contend for 4 cycles, then host is served
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'(i + 8), 32'h0, 1'b1, 1'b0, 16'd3, 32'h0);
      chk1("contend_gnt", 0, o_gnt[0], 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 16'd3, 32'h0);
    chk1("hst_l1_vld", 0, o_hv[0], 1'b1);
    idle();
    chk1("hst_l2_vld", 1, o_hv[1], 1'b1);
    chk32("hst_l2_d", 1, o_hd[1], ref_mem[3]);
    idle(); idle(); idle();

    // Out-of-range read and write
    mrd(16'd1024);
    chk1 ("oor_vld", 0, o_mv[0], 1'b1);
    chk32("oor_data", 0, o_md[0], 32'h0);
    chk1 ("oor_flag", 0, o_oor[0], 1'b1);
    mwr(16'd1024, 32'hBADBAD);
    mrd(16'd0);  chk32("oor_no_alias", 0, o_md[0], 32'h11);
    idle(); idle(); idle();
    chk1("oor_sticky", 3, o_oor[3], 1'b1);

    // Reset with reads in flight (RD_LAT=4 instance is index 3)
    mrd(16'd0); mrd(16'd1); mrd(16'd2);
    step(1'b1, 1'b1, 1'b1, 16'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 16'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk1 ("rst_fl_vld", 3, o_mv[3], 1'b0);
      chk32("rst_fl_d", 3, o_md[3], 32'h0);
      chk1 ("rst_fl_oor", 3, o_oor[3], 1'b0);
    end
    mrd(16'd0);  chk32("rst_wr_drop", 0, o_md[0], 32'h11);

    // Randomised interleaved traffic with occasional resets
    for (int i = 0; i < 700; i++) begin
      step(1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), pick_addr(), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), pick_addr(), $urandom);
    end
    for (int i = 0; i < 6; i++) idle();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
